zhegalkin_analyzer: RTL and testbench

Sequential analyzer that runs in the opposite direction to the team's 4-input function implementations (ROM, MDNF, Zhegalkin, Pierce/Sheffer, UDP forms). The existing blocks map a function description to an output `y`. This block drives all 16 input vectors into a function under test, captures `y` into a truth table, and decodes that table back into Zhegalkin (ANF) coefficients with an in-place Möbius transform. It sits in the self-check/characterisation path next to the function implementations, and its `x` output drives the DUT inputs directly.

---
 rtl/zhegalkin_analyzer.sv | 167 ++++++++++++++++
 tb/tb_zhegalkin_analyzer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/zhegalkin_analyzer.sv
// ---------------------------------------------------------------------------
// zhegalkin_analyzer
//
// Drives all 16 input vectors into a 4-input function under test, captures
// its response y into a truth table, then decodes that table into Zhegalkin
// (ANF) coefficients with a four-stage in-place Moebius transform.
//
// Parameters:
//   SETTLE  cycles each vector is held on x before y is sampled (1..15)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   run request, honoured only in IDLE
//   y       response of the function under test to x
//   x       stimulus vector (x[3] is MSB)
//   busy    high while a run is in progress
//   done    one-cycle pulse when tt/anf/weight update
//   tt      truth table, tt[i] = f(x=i)
//   anf     Zhegalkin coefficients, anf[m] = coefficient of prod x[k], k in m
//   weight  number of ones in tt
// ---------------------------------------------------------------------------
module zhegalkin_analyzer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  output logic [3:0]  x,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [15:0] anf,
  output logic [4:0]  weight
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    MOBIUS  = 2'd2
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [3:0]     idx_reg;
  logic [CW-1:0]  cnt_reg;
  logic [1:0]     stg_reg;
  logic [15:0]    work_reg;
  logic [15:0]    cap_reg;    // untouched copy of the table; work is transformed in place
  logic           done_reg;
  logic [15:0]    tt_reg;
  logic [15:0]    anf_reg;
  logic [4:0]     weight_reg;

  logic           sample;
  logic           last_vec;
  logic [3:0]     stg_mask;
  logic [15:0]    mob;

  assign sample   = (state_reg == CAPTURE) && (cnt_reg == CNT_LAST);
  assign last_vec = sample && (idx_reg == 4'd15);

  // One butterfly stage: every index with the stage bit set absorbs its
  // partner with that bit cleared. Reads only registered work, so each stage
  // sees the complete result of the previous one.
  assign stg_mask = 4'b0001 << stg_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mob
      localparam logic [3:0] M = 4'(gi);
      assign mob[gi] = (|(M & stg_mask)) ? (work_reg[gi] ^ work_reg[M ^ stg_mask])
                                         : work_reg[gi];
    end
  endgenerate

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 16; i++) begin
      s = s + 5'(v[i]);
    end
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)            state_next = CAPTURE;
      CAPTURE: if (last_vec)         state_next = MOBIUS;
      MOBIUS:  if (stg_reg == 2'd3)  state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg    <= 4'd0;
      cnt_reg    <= '0;
      stg_reg    <= 2'd0;
      work_reg   <= 16'd0;
      cap_reg    <= 16'd0;
      done_reg   <= 1'b0;
      tt_reg     <= 16'd0;
      anf_reg    <= 16'd0;
      weight_reg <= 5'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg <= 4'd0;
            cnt_reg <= '0;
          end
        end
        CAPTURE: begin
          if (sample) begin
            work_reg[idx_reg] <= y;
            cap_reg[idx_reg]  <= y;
            if (idx_reg == 4'd15) begin
              stg_reg <= 2'd0;
            end else begin
              idx_reg <= idx_reg + 4'd1;
              cnt_reg <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        MOBIUS: begin
          work_reg <= mob;
          stg_reg  <= stg_reg + 2'd1;
          if (stg_reg == 2'd3) begin
            done_reg   <= 1'b1;
            anf_reg    <= mob;
            tt_reg     <= cap_reg;
            weight_reg <= popcount16(cap_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign x      = (state_reg == CAPTURE) ? idx_reg : 4'd0;
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign tt     = tt_reg;
  assign anf    = anf_reg;
  assign weight = weight_reg;

endmodule

// File: tb/tb_zhegalkin_analyzer.sv
module tb_zhegalkin_analyzer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SETTLE=2, function under test selected by fn_sel
  logic        rst_n, start, y;
  logic [3:0]  x;
  logic        busy, done;
  logic [15:0] tt, anf;
  logic [4:0]  weight;

  // Instance B: SETTLE=1, AND4
  logic        rst2_n, start2, y2;
  logic [3:0]  x2;
  logic        busy2, done2;
  logic [15:0] tt2, anf2;
  logic [4:0]  weight2;

  int checks = 0;
  int errors = 0;
  int fn_sel = 0;
  logic [15:0] ref_tt = 16'h0AC5;   // reference 4-input function (UDP form)

  always_comb begin
    case (fn_sel)
      0:       y = ref_tt[x];
      1:       y = 1'b1;
      2:       y = ^x;
      default: y = 1'b0;
    endcase
  end
  assign y2 = &x2;

  zhegalkin_analyzer #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .x(x), .busy(busy),
    .done(done), .tt(tt), .anf(anf), .weight(weight)
  );

  zhegalkin_analyzer #(.SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .y(y2), .x(x2), .busy(busy2),
    .done(done2), .tt(tt2), .anf(anf2), .weight(weight2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one edge, then follow the run. Returns the cycle number
  // (cycle 1 = cycle after the start edge) in which done is seen, and the
  // number of cycles with busy high. Ends sampled in the done cycle.
  task automatic run_a(input logic hold_start, output int n_done, output int n_busy);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    n_done = 1;
    n_busy = 0;
    while (!done && n_done < 200) begin
      if (busy) n_busy++;
      @(posedge clk); #1;
      n_done++;
    end
  endtask

  initial begin
    int nd, nb;
    rst_n = 1'b0; start = 1'b0; rst2_n = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_tt", 32'(tt), 32'd0);
    check("rst_anf", 32'(anf), 32'd0);
    check("rst_weight", 32'(weight), 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;

    // Reference function
    fn_sel = 0;
    run_a(1'b0, nd, nb);
    check("ref_done_cycle", 32'(nd), 32'd37);
    check("ref_busy_cycles", 32'(nb), 32'd36);
    check("ref_done", 32'(done), 32'd1);
    check("ref_tt", 32'(tt), 32'h0AC5);
    check("ref_anf", 32'(anf), 32'h5173);
    check("ref_weight", 32'(weight), 32'd6);
    @(posedge clk); #1;
    check("ref_done_pulse", 32'(done), 32'd0);

    // Constant one
    fn_sel = 1;
    run_a(1'b0, nd, nb);
    check("one_tt", 32'(tt), 32'hFFFF);
    check("one_anf", 32'(anf), 32'h0001);
    check("one_weight", 32'(weight), 32'd16);
    @(posedge clk); #1;

    // Parity with start held high: one run, then a second from the done cycle
    fn_sel = 2;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    check("hold_mid_tt", 32'(tt), 32'hFFFF);
    check("hold_mid_busy", 32'(busy), 32'd1);
    nd = 11;
    while (!done && nd < 200) begin @(posedge clk); #1; nd++; end
    check("par_done_cycle", 32'(nd), 32'd37);
    check("par_tt", 32'(tt), 32'h6996);
    check("par_anf", 32'(anf), 32'h0116);
    check("par_weight", 32'(weight), 32'd8);
    fn_sel = 1;   // second run captures the constant one
    @(posedge clk); #1;
    check("second_busy", 32'(busy), 32'd1);
    check("second_done_low", 32'(done), 32'd0);
    start = 1'b0;
    nd = 1;
    while (!done && nd < 200) begin
      if (nd == 20) check("second_hold_anf", 32'(anf), 32'h0116);
      @(posedge clk); #1; nd++;
    end
    check("second_done_cycle", 32'(nd), 32'd37);
    check("second_tt", 32'(tt), 32'hFFFF);
    @(posedge clk); #1;
    check("no_third_run", 32'(busy), 32'd0);

    // Reset at cycle 10 of a run
    fn_sel = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_x", 32'(x), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_tt", 32'(tt), 32'd0);
    check("mid_rst_anf", 32'(anf), 32'd0);
    check("mid_rst_weight", 32'(weight), 32'd0);
    @(posedge clk); #1;
    check("rst_ignores_start", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    fn_sel = 0;
    run_a(1'b0, nd, nb);
    check("post_rst_done_cycle", 32'(nd), 32'd37);
    check("post_rst_tt", 32'(tt), 32'h0AC5);
    check("post_rst_anf", 32'(anf), 32'h5173);
    check("post_rst_weight", 32'(weight), 32'd6);

    // AND4 on SETTLE=1 instance
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    nd = 1; nb = 0;
    while (!done2 && nd < 200) begin
      if (nd <= 16) check($sformatf("and4_x_%0d", nd), 32'(x2), 32'(nd - 1));
      if (busy2) nb++;
      @(posedge clk); #1; nd++;
    end
    check("and4_busy_cycles", 32'(nb), 32'd20);
    check("and4_done_cycle", 32'(nd), 32'd21);
    check("and4_tt", 32'(tt2), 32'h8000);
    check("and4_anf", 32'(anf2), 32'h8000);
    check("and4_weight", 32'(weight2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
